// File: rtl/lru_matrix_multiset.sv
// True-LRU replacement engine: one NUM_WAY x NUM_WAY age matrix per set.
// Victim queries read the current matrix and answer one cycle later; invalid ways win, locked ways never do.
module lru_matrix_multiset #(
  parameter int NUM_SET   = 64,
  parameter int SET_DEPTH = 6,
  parameter int NUM_WAY   = 4,
  parameter int WAY_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 update_i,
  input  logic [SET_DEPTH-1:0] update_set_i,
  input  logic [WAY_DEPTH-1:0] update_way_i,
  input  logic                 demote_i,
  input  logic [SET_DEPTH-1:0] demote_set_i,
  input  logic [WAY_DEPTH-1:0] demote_way_i,
  input  logic                 query_i,
  input  logic [SET_DEPTH-1:0] query_set_i,
  input  logic [NUM_WAY-1:0]   valid_mask_i,
  input  logic [NUM_WAY-1:0]   lock_mask_i,
  output logic                 victim_vld_o,
  output logic                 victim_found_o,
  output logic [WAY_DEPTH-1:0] victim_way_o
);

  // Row j, bit k set: way j was used more recently than way k.
  typedef logic [NUM_WAY-1:0][NUM_WAY-1:0] mat_t;

  mat_t                 mat_r [NUM_SET];
  logic                 victim_vld_r;
  logic                 victim_found_r;
  logic [WAY_DEPTH-1:0] victim_way_r;

  logic                 upd_ok_s;
  logic                 dem_ok_s;
  logic                 dem_write_s;
  mat_t                 upd_mat_s;
  mat_t                 dem_mat_s;
  mat_t                 q_mat_s;
  logic [NUM_WAY-1:0]   cand_s;
  logic [NUM_WAY-1:0]   inval_s;
  logic [NUM_WAY-1:0]   oldest_s;
  logic                 found_s;
  logic [WAY_DEPTH-1:0] way_s;

  function automatic mat_t promote(input mat_t m, input logic [WAY_DEPTH-1:0] w);
    mat_t r;
    r = m;
    for (int j = 0; j < NUM_WAY; j++) begin
      for (int k = 0; k < NUM_WAY; k++) begin
        if (j == int'(w)) begin
          r[j][k] = (k != int'(w));
        end else if (k == int'(w)) begin
          r[j][k] = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic mat_t demote(input mat_t m, input logic [WAY_DEPTH-1:0] w);
    mat_t r;
    r = m;
    for (int j = 0; j < NUM_WAY; j++) begin
      for (int k = 0; k < NUM_WAY; k++) begin
        if (j == int'(w)) begin
          r[j][k] = 1'b0;
        end else if (k == int'(w)) begin
          r[j][k] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [WAY_DEPTH-1:0] lowest(input logic [NUM_WAY-1:0] m);
    logic [WAY_DEPTH-1:0] r;
    r = '0;
    for (int j = NUM_WAY - 1; j >= 0; j--) begin
      if (m[j]) begin
        r = WAY_DEPTH'(j);
      end
    end
    return r;
  endfunction

  // Update path: a same-set demote is folded into the promote write so one write carries both.
  always_comb begin
    upd_ok_s = update_i && (int'(update_set_i) < NUM_SET) && (int'(update_way_i) < NUM_WAY);
    dem_ok_s = demote_i && (int'(demote_set_i) < NUM_SET) && (int'(demote_way_i) < NUM_WAY);
    upd_mat_s = promote(mat_r[update_set_i], update_way_i);
    dem_mat_s = demote(mat_r[demote_set_i], demote_way_i);
    if (upd_ok_s && dem_ok_s && (update_set_i == demote_set_i)) begin
      dem_write_s = 1'b0;
      if (update_way_i != demote_way_i) begin
        upd_mat_s = demote(upd_mat_s, demote_way_i);
      end else begin
        upd_mat_s = upd_mat_s;
      end
    end else begin
      dem_write_s = dem_ok_s;
    end
  end

  // Victim select on the pre-update matrix of the queried set.
  always_comb begin
    q_mat_s  = mat_r[query_set_i];
    cand_s   = ~lock_mask_i;
    inval_s  = cand_s & ~valid_mask_i;
    oldest_s = '0;
    for (int j = 0; j < NUM_WAY; j++) begin
      oldest_s[j] = cand_s[j] && ((q_mat_s[j] & cand_s) == '0);
    end
    found_s = |cand_s;
    if (!found_s) begin
      way_s = '0;
    end else if (|inval_s) begin
      way_s = lowest(inval_s);
    end else if (|oldest_s) begin
      way_s = lowest(oldest_s);
    end else begin
      way_s = lowest(cand_s);
    end
  end

  // Matrix state and registered query response.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SET; s++) begin
        mat_r[s] <= '0;
      end
      victim_vld_r   <= 1'b0;
      victim_found_r <= 1'b0;
      victim_way_r   <= '0;
    end else begin
      if (upd_ok_s) begin
        mat_r[update_set_i] <= upd_mat_s;
      end
      if (dem_write_s) begin
        mat_r[demote_set_i] <= dem_mat_s;
      end
      victim_vld_r   <= query_i;
      victim_found_r <= query_i && found_s;
      victim_way_r   <= query_i ? way_s : '0;
    end
  end

  assign victim_vld_o   = victim_vld_r;
  assign victim_found_o = victim_found_r;
  assign victim_way_o   = victim_way_r;

endmodule

// File: tb/tb_lru_matrix_multiset.sv
// Directed self-checking bench for lru_matrix_multiset with hand-computed victims.
module tb_lru_matrix_multiset;

  logic       clk;
  logic       rst;
  logic       update_i;
  logic [5:0] update_set_i;
  logic [1:0] update_way_i;
  logic       demote_i;
  logic [5:0] demote_set_i;
  logic [1:0] demote_way_i;
  logic       query_i;
  logic [5:0] query_set_i;
  logic [3:0] valid_mask_i;
  logic [3:0] lock_mask_i;
  logic       victim_vld_o;
  logic       victim_found_o;
  logic [1:0] victim_way_o;

  int checks;
  int errors;

  lru_matrix_multiset dut (
    .clk            (clk),
    .rst            (rst),
    .update_i       (update_i),
    .update_set_i   (update_set_i),
    .update_way_i   (update_way_i),
    .demote_i       (demote_i),
    .demote_set_i   (demote_set_i),
    .demote_way_i   (demote_way_i),
    .query_i        (query_i),
    .query_set_i    (query_set_i),
    .valid_mask_i   (valid_mask_i),
    .lock_mask_i    (lock_mask_i),
    .victim_vld_o   (victim_vld_o),
    .victim_found_o (victim_found_o),
    .victim_way_o   (victim_way_o)
  );

  always #5 clk = ~clk;

  task automatic idle();
    update_i     = 1'b0;
    update_set_i = 6'd0;
    update_way_i = 2'd0;
    demote_i     = 1'b0;
    demote_set_i = 6'd0;
    demote_way_i = 2'd0;
    query_i      = 1'b0;
    query_set_i  = 6'd0;
    valid_mask_i = 4'hF;
    lock_mask_i  = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic promote(input logic [5:0] s, input logic [1:0] w);
    update_i = 1'b1; update_set_i = s; update_way_i = w;
    tick();
    update_i = 1'b0;
  endtask

  task automatic query(input logic [5:0] s, input logic [3:0] v, input logic [3:0] l);
    query_i = 1'b1; query_set_i = s; valid_mask_i = v; lock_mask_i = l;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (victim_vld_o !== 1'b0 || victim_found_o !== 1'b0 || victim_way_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0b/%0b/%0d want 0/0/0", victim_vld_o, victim_found_o, victim_way_o);
    end
    rst = 1'b0;
    query(6'd0, 4'hF, 4'h0);
    checks++;
    if (victim_vld_o !== 1'b1 || victim_found_o !== 1'b1 || victim_way_o !== 2'd0) begin
      errors++;
      $display("FAIL first_query: got %0b/%0b/%0d want 1/1/0", victim_vld_o, victim_found_o, victim_way_o);
    end
    tick();
    checks++;
    if (victim_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL vld_one_cycle: got vld=%0b want 0", victim_vld_o);
    end
  endtask

  task automatic test_promote_order();
    for (int w = 0; w < 4; w++) promote(6'd5, 2'(w));
    query(6'd5, 4'hF, 4'h0);
    checks++;
    if (victim_vld_o !== 1'b1 || victim_found_o !== 1'b1 || victim_way_o !== 2'd0) begin
      errors++;
      $display("FAIL promote_order: got %0b/%0b/%0d want 1/1/0", victim_vld_o, victim_found_o, victim_way_o);
    end
    promote(6'd5, 2'd0);
    query(6'd5, 4'hF, 4'h0);
    checks++;
    if (victim_vld_o !== 1'b1 || victim_found_o !== 1'b1 || victim_way_o !== 2'd1) begin
      errors++;
      $display("FAIL promote_again: got %0b/%0b/%0d want 1/1/1", victim_vld_o, victim_found_o, victim_way_o);
    end
  endtask

  task automatic test_lock();
    query(6'd5, 4'hF, 4'b0010);
    checks++;
    if (victim_vld_o !== 1'b1 || victim_found_o !== 1'b1 || victim_way_o !== 2'd2) begin
      errors++;
      $display("FAIL lock_lru: got %0b/%0b/%0d want 1/1/2", victim_vld_o, victim_found_o, victim_way_o);
    end
    query(6'd5, 4'hF, 4'hF);
    checks++;
    if (victim_vld_o !== 1'b1 || victim_found_o !== 1'b0 || victim_way_o !== 2'd0) begin
      errors++;
      $display("FAIL lock_all: got %0b/%0b/%0d want 1/0/0", victim_vld_o, victim_found_o, victim_way_o);
    end
  endtask

  task automatic test_invalid();
    query(6'd5, 4'b0111, 4'h0);
    checks++;
    if (victim_vld_o !== 1'b1 || victim_found_o !== 1'b1 || victim_way_o !== 2'd3) begin
      errors++;
      $display("FAIL invalid_pref: got %0b/%0b/%0d want 1/1/3", victim_vld_o, victim_found_o, victim_way_o);
    end
  endtask

  task automatic test_same_cycle();
    // Order 1,2,3,0 -> promote 1, demote 2 -> order 2,3,0,1 (LRU first).
    update_i = 1'b1; update_set_i = 6'd5; update_way_i = 2'd1;
    demote_i = 1'b1; demote_set_i = 6'd5; demote_way_i = 2'd2;
    query(6'd5, 4'hF, 4'h0);
    checks++;
    if (victim_vld_o !== 1'b1 || victim_found_o !== 1'b1 || victim_way_o !== 2'd1) begin
      errors++;
      $display("FAIL same_cycle_old: got %0b/%0b/%0d want 1/1/1", victim_vld_o, victim_found_o, victim_way_o);
    end
    query(6'd5, 4'hF, 4'h0);
    checks++;
    if (victim_way_o !== 2'd2 || victim_found_o !== 1'b1) begin
      errors++;
      $display("FAIL promote_demote: got found=%0b way=%0d want 1/2", victim_found_o, victim_way_o);
    end
    query(6'd6, 4'hF, 4'h0);
    checks++;
    if (victim_way_o !== 2'd0 || victim_found_o !== 1'b1) begin
      errors++;
      $display("FAIL set6_untouched: got found=%0b way=%0d want 1/0", victim_found_o, victim_way_o);
    end
    // Same way: promote wins -> order 3,0,1,2.
    update_i = 1'b1; update_set_i = 6'd5; update_way_i = 2'd2;
    demote_i = 1'b1; demote_set_i = 6'd5; demote_way_i = 2'd2;
    tick();
    idle();
    query(6'd5, 4'hF, 4'h0);
    checks++;
    if (victim_way_o !== 2'd3) begin
      errors++;
      $display("FAIL same_way_promote_wins: got way=%0d want 3", victim_way_o);
    end
    // Different sets: set 5 demote 1 -> LRU 1; set 6 promote 0 -> lowest old row is 1.
    update_i = 1'b1; update_set_i = 6'd6; update_way_i = 2'd0;
    demote_i = 1'b1; demote_set_i = 6'd5; demote_way_i = 2'd1;
    tick();
    idle();
    query(6'd5, 4'hF, 4'h0);
    checks++;
    if (victim_way_o !== 2'd1) begin
      errors++;
      $display("FAIL diff_set_demote: got way=%0d want 1", victim_way_o);
    end
    query(6'd6, 4'hF, 4'h0);
    checks++;
    if (victim_way_o !== 2'd1) begin
      errors++;
      $display("FAIL diff_set_promote: got way=%0d want 1", victim_way_o);
    end
  endtask

  task automatic test_back_to_back();
    query_i = 1'b1; query_set_i = 6'd5; valid_mask_i = 4'hF; lock_mask_i = 4'h0;
    tick();
    checks++;
    if (victim_vld_o !== 1'b1 || victim_way_o !== 2'd1) begin
      errors++;
      $display("FAIL b2b_first: got vld=%0b way=%0d want 1/1", victim_vld_o, victim_way_o);
    end
    query_set_i = 6'd6; lock_mask_i = 4'b0010;
    tick();
    checks++;
    if (victim_vld_o !== 1'b1 || victim_way_o !== 2'd2) begin
      errors++;
      $display("FAIL b2b_second: got vld=%0b way=%0d want 1/2", victim_vld_o, victim_way_o);
    end
    query_set_i = 6'd0; lock_mask_i = 4'h0;
    tick();
    checks++;
    if (victim_vld_o !== 1'b1 || victim_way_o !== 2'd0) begin
      errors++;
      $display("FAIL b2b_third: got vld=%0b way=%0d want 1/0", victim_vld_o, victim_way_o);
    end
    idle();
    tick();
    checks++;
    if (victim_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drop: got vld=%0b want 0", victim_vld_o);
    end
  endtask

  task automatic test_reset_midop();
    query(6'd5, 4'hF, 4'h0);
    checks++;
    if (victim_vld_o !== 1'b1 || victim_way_o !== 2'd1) begin
      errors++;
      $display("FAIL pre_reset_query: got vld=%0b way=%0d want 1/1", victim_vld_o, victim_way_o);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (victim_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_after_query: got vld=%0b want 0", victim_vld_o);
    end
    rst = 1'b0;
    promote(6'd5, 2'd0);
    query_i = 1'b1; query_set_i = 6'd5;
    update_i = 1'b1; update_set_i = 6'd5; update_way_i = 2'd1;
    rst = 1'b1;
    tick();
    idle();
    rst = 1'b0;
    checks++;
    if (victim_vld_o !== 1'b0 || victim_found_o !== 1'b0 || victim_way_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_drops_query: got %0b/%0b/%0d want 0/0/0", victim_vld_o, victim_found_o, victim_way_o);
    end
    query(6'd5, 4'hF, 4'h0);
    checks++;
    if (victim_vld_o !== 1'b1 || victim_way_o !== 2'd0) begin
      errors++;
      $display("FAIL set5_cleared: got vld=%0b way=%0d want 1/0", victim_vld_o, victim_way_o);
    end
    query(6'd6, 4'hF, 4'h0);
    checks++;
    if (victim_vld_o !== 1'b1 || victim_way_o !== 2'd0) begin
      errors++;
      $display("FAIL set6_cleared: got vld=%0b way=%0d want 1/0", victim_vld_o, victim_way_o);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_promote_order();
    test_lock();
    test_invalid();
    test_same_cycle();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
